// File: rtl/kulisch_acc_fp16.sv
// Exact Kulisch accumulator for FP16 carry-save products.
// Resolves, aligns and sums terms into a wide two's-complement register.
module kulisch_acc_fp16 #(
    parameter int MWIDTH    = 10,
    parameter int EWIDTH    = 5,
    parameter int ACC_WIDTH = 96,
    parameter int PWIDTH    = 2 * MWIDTH + 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [PWIDTH-1:0]    i_sum,
    input  logic [PWIDTH-1:0]    i_carry,
    input  logic [EWIDTH:0]      i_exp,
    input  logic                 i_sign,
    input  logic                 i_exception,
    input  logic                 i_last,
    input  logic                 i_clear,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [ACC_WIDTH-1:0] o_acc,
    output logic                 o_exception,
    output logic                 o_overflow
);

    typedef enum logic [1:0] {
        S_ACC,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                 r_s1_valid;
    logic [PWIDTH-1:0]    r_p;
    logic [EWIDTH:0]      r_shift;
    logic                 r_sign;
    logic                 r_last;
    logic                 r_s1_exc;

    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_exc;
    logic                 r_ovf;

    logic                 w_in_acc;
    logic                 w_accept;
    logic                 w_clear;
    logic                 w_release;
    logic [PWIDTH-1:0]    w_p;
    logic [ACC_WIDTH-1:0] w_term;
    logic [ACC_WIDTH-1:0] w_addend;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_ovf;

    assign w_in_acc  = (r_state == S_ACC);
    assign w_accept  = i_valid & w_in_acc;
    assign w_clear   = i_clear & w_in_acc;
    assign w_release = (r_state == S_OUT) & o_ready;

    assign i_ready     = w_in_acc;
    assign o_valid     = (r_state == S_OUT);
    assign o_acc       = r_acc;
    assign o_exception = r_exc;
    assign o_overflow  = r_ovf;

    // Carry-save pair resolves modulo 2^PWIDTH; the true product never exceeds it.
    assign w_p = i_sum + i_carry;

    assign w_term   = ACC_WIDTH'(r_p) << r_shift;
    assign w_addend = r_sign ? ('0 - w_term) : w_term;
    assign w_sum    = r_acc + w_addend;

    // Overflow: both operands share a sign that the result does not.
    assign w_ovf = (r_acc[ACC_WIDTH-1] == w_addend[ACC_WIDTH-1]) &&
                   (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_ACC: begin
                if (w_accept && i_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_s1_valid || r_last) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                if (o_ready) begin
                    w_next = S_ACC;
                end
            end
            default: begin
                w_next = S_ACC;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s1_valid <= 1'b0;
            r_p        <= '0;
            r_shift    <= '0;
            r_sign     <= 1'b0;
            r_last     <= 1'b0;
            r_s1_exc   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_p      <= w_p;
                r_shift  <= i_exp - (EWIDTH+1)'(2);
                r_sign   <= i_sign;
                r_last   <= i_last;
                r_s1_exc <= i_exception;
            end
        end
    end

    // A clear drops whatever sits in stage 1 and restarts the sum.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_acc <= '0;
            r_exc <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_clear || w_release) begin
            r_acc <= '0;
            r_exc <= 1'b0;
            r_ovf <= 1'b0;
        end else if (r_s1_valid) begin
            if (r_s1_exc) begin
                r_exc <= 1'b1;
            end else begin
                r_acc <= w_sum;
                if (w_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_kulisch_acc_fp16.sv
// Scoreboard bench for kulisch_acc_fp16.
// Terms are modelled on drive; sums are compared at the output handshake.
module tb_kulisch_acc_fp16;

    logic        CLK;
    logic        RST;
    logic        i_valid;
    logic        i_ready;
    logic [21:0] i_sum;
    logic [21:0] i_carry;
    logic [5:0]  i_exp;
    logic        i_sign;
    logic        i_exception;
    logic        i_last;
    logic        i_clear;
    logic        o_valid;
    logic        o_ready;
    logic [95:0] o_acc;
    logic        o_exception;
    logic        o_overflow;

    kulisch_acc_fp16 dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_sum       (i_sum),
        .i_carry     (i_carry),
        .i_exp       (i_exp),
        .i_sign      (i_sign),
        .i_exception (i_exception),
        .i_last      (i_last),
        .i_clear     (i_clear),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_acc       (o_acc),
        .o_exception (o_exception),
        .o_overflow  (o_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [95:0] acc;
        logic        exc;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [95:0] m_acc;
    logic        m_exc;
    logic        m_ovf;
    logic [95:0] last_acc;
    logic [95:0] c_max;
    logic [95:0] c_big;
    logic [95:0] c_neg1;

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        m_acc = '0;
        m_exc = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic send(input logic [21:0] s, input logic [21:0] c,
                        input logic [5:0] e, input logic sg,
                        input logic ex, input logic lst, input logic clr);
        int          n;
        logic [21:0] p;
        logic [95:0] mag;
        logic [95:0] v;
        logic [96:0] full;
        n = 0;
        @(negedge CLK);
        while (!i_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 96'd0, 96'd1);
        #1;
        i_valid     = 1'b1;
        i_sum       = s;
        i_carry     = c;
        i_exp       = e;
        i_sign      = sg;
        i_exception = ex;
        i_last      = lst;
        i_clear     = clr;
        if (clr) model_clear();
        p = s + c;
        if (ex) begin
            m_exc = 1'b1;
        end else begin
            mag  = 96'(p) << (e - 6'd2);
            v    = sg ? (96'd0 - mag) : mag;
            full = {m_acc[95], m_acc} + {v[95], v};
            if (full[96] != full[95]) m_ovf = 1'b1;
            m_acc = full[95:0];
        end
        if (lst) begin
            q.push_back('{m_acc, m_exc, m_ovf});
            model_clear();
        end
        @(posedge CLK);
    endtask

    task automatic idle();
        @(negedge CLK);
        #1;
        i_valid     = 1'b0;
        i_last      = 1'b0;
        i_clear     = 1'b0;
        i_exception = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (q.size() != 0) begin
            chk("out_timeout", 96'd0, 96'd1);
            q.delete();
        end
    endtask

    always @(negedge CLK) begin : mon
        exp_t e;
        #2;
        if (RST && o_valid && o_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 96'd1, 96'd0);
            end else begin
                e = q.pop_front();
                chk("acc", o_acc, e.acc);
                chk("exc", 96'(o_exception), 96'(e.exc));
                chk("ovf", 96'(o_overflow), 96'(e.ovf));
                last_acc = o_acc;
            end
        end
    end

    initial begin
        int n;
        RST = 1'b0;
        i_valid = 1'b0;
        i_sum = '0;
        i_carry = '0;
        i_exp = 6'd2;
        i_sign = 1'b0;
        i_exception = 1'b0;
        i_last = 1'b0;
        i_clear = 1'b0;
        o_ready = 1'b1;
        last_acc = '0;
        model_clear();
        c_max  = 96'h3FF001;
        c_max  = c_max << 58;
        c_big  = c_max << 15;
        c_neg1 = 96'd0 - 96'h1_0000_0000_0000;

        repeat (3) @(negedge CLK);
        chk("rst_acc", o_acc, 96'd0);
        chk("rst_valid", 96'(o_valid), 96'd0);
        chk("rst_exc", 96'(o_exception), 96'd0);
        chk("rst_ovf", 96'(o_overflow), 96'd0);
        #1 RST = 1'b1;
        @(negedge CLK);
        chk("ready_after_rst", 96'(i_ready), 96'd1);

        // 1.0 * 1.0 from a split carry-save pair
        send(22'h0F0000, 22'h010000, 6'd30, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("drain_ready", 96'(i_ready), 96'd0);
        chk("drain_valid", 96'(o_valid), 96'd0);
        @(negedge CLK);
        chk("out_valid", 96'(o_valid), 96'd1);
        chk("out_ready", 96'(i_ready), 96'd0);
        wait_out();
        chk("one_const", last_acc, 96'h1_0000_0000_0000);

        send(22'h100000, 22'h0, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        send(22'h100000, 22'h0, 6'd30, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        wait_out();
        chk("cancel_const", last_acc, 96'd0);

        send(22'h3FF001, 22'h0, 6'd60, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        wait_out();
        chk("max_const", last_acc, c_max);
        send(22'h0, 22'h1, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        wait_out();
        chk("min_const", last_acc, 96'd1);
        send(22'h0, 22'h0, 6'd60, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        wait_out();
        chk("zero_const", last_acc, 96'd0);

        send(22'h100000, 22'h0, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        send(22'h100000, 22'h0, 6'd31, 1'b0, 1'b0, 1'b0, 1'b0);
        send(22'h3FF001, 22'h0, 6'd60, 1'b1, 1'b1, 1'b0, 1'b0);
        send(22'h100000, 22'h0, 6'd29, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        wait_out();
        chk("exc_sum", last_acc, 96'h3_8000_0000_0000);

        send(22'h100000, 22'h0, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        send(22'h100000, 22'h0, 6'd31, 1'b0, 1'b1, 1'b0, 1'b0);
        send(22'h100000, 22'h0, 6'd29, 1'b0, 1'b0, 1'b0, 1'b1);
        send(22'h100000, 22'h0, 6'd30, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        wait_out();
        chk("clear_sum", last_acc, 96'h1_8000_0000_0000);
        send(22'h3FF001, 22'h0, 6'd50, 1'b0, 1'b0, 1'b0, 1'b0);
        send(22'h0F0000, 22'h010000, 6'd30, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();
        wait_out();
        chk("clear_last", last_acc, c_neg1);

        #1 o_ready = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            send(22'h3FF001, 22'h0, 6'd60, 1'b0, 1'b0, i == 32767, 1'b0);
        end
        idle();
        n = 0;
        while (!o_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("big_valid", 96'(o_valid), 96'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_acc", o_acc, c_big);
            chk("hold_ready", 96'(i_ready), 96'd0);
        end
        #1 o_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("ready_after_hs", 96'(i_ready), 96'd1);
        send(22'h100000, 22'h0, 6'd30, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        wait_out();

        send(22'h100000, 22'h0, 6'd30, 1'b0, 1'b1, 1'b0, 1'b0);
        send(22'h100000, 22'h0, 6'd40, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("pre_rst_exc", 96'(o_exception), 96'd1);
        #1;
        RST = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("mid_rst_acc", o_acc, 96'd0);
        chk("mid_rst_valid", 96'(o_valid), 96'd0);
        chk("mid_rst_exc", 96'(o_exception), 96'd0);
        chk("mid_rst_ovf", 96'(o_overflow), 96'd0);
        model_clear();
        @(negedge CLK);
        #1 RST = 1'b1;
        repeat (5) @(negedge CLK);
        chk("post_rst_valid", 96'(o_valid), 96'd0);
        chk("post_rst_acc", o_acc, 96'd0);
        send(22'h100000, 22'h0, 6'd30, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        wait_out();
        chk("post_rst_sum", last_acc, 96'h1_0000_0000_0000);

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/kulisch_acc_fp16.md
Name: kulisch_acc_fp16

Overview:
- Sequential Kulisch (exact fixed-point) accumulator directly downstream of the FP16 Booth multiplier stage.
- Consumes one carry-save mantissa product per cycle, with its sign and exponent sum, and resolves the carry-save pair.
- Aligns each product by exponent and adds it exactly into a wide two's-complement register.
- Presents the exact dot-product sum with a valid/ready handshake when a term flagged last has been absorbed.

Parameters:
- MWIDTH, 10, mantissa fraction bits; product width PWIDTH = 2*MWIDTH+2 = 22.
- EWIDTH, 5, operand exponent bits; exponent-sum input is EWIDTH+1 = 6 bits.
- ACC_WIDTH, 96, accumulator width: 81 bits of product span plus 15 carry guard bits.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input term valid.
- i_ready  out  1  block accepts a term this cycle.
- i_sum  in  PWIDTH  carry-save product, sum vector.
- i_carry  in  PWIDTH  carry-save product, carry vector.
- i_exp  in  EWIDTH+1  effective exponent sum: each operand exponent clamped to min 1; legal 2..60.
- i_sign  in  1  product sign; 1 = subtract.
- i_exception  in  1  term is NaN/Inf.
- i_last  in  1  final term of the current sum.
- i_clear  in  1  synchronous abort/clear of the current sum.
- o_valid  out  1  o_acc holds a completed sum.
- o_ready  in  1  consumer accepts o_acc.
- o_acc  out  ACC_WIDTH  exact sum, two's complement; LSB weight 2^-48.
- o_exception  out  1  sticky: any accepted term had i_exception.
- o_overflow  out  1  sticky: signed overflow of the accumulator add.

Behaviour:
- Reset (RST=0, asynchronous): state ACC; accumulator, stage-1 register, o_acc, o_valid, o_exception and o_overflow all 0.
- After reset release, i_ready=1.
- Accept condition: i_valid & i_ready at a rising edge.

Stage 1, on accept:
- Register P = (i_sum + i_carry) mod 2^PWIDTH.
- Register shift = i_exp - 2 (0..58), sign, last, exc.
- Set stage-1 valid.
- i_exp outside 2..60 is undefined input; no check is made.

Stage 2, one edge later:
- Compute term = zero-extend(P) << shift.
- Add the term to the accumulator (negated if sign=1).
- Exc terms are not added; they set o_exception.
- Signed overflow of the add sets o_overflow; the accumulator wraps modulo 2^ACC_WIDTH.
- Throughput: 1 term per cycle in ACC state.

FSM:
- ACC: i_ready=1.
  - Accepted term with i_last=1 -> DRAIN.
- DRAIN: i_ready=0. The final stage-1 term is absorbed at this edge -> OUT.
- OUT: i_ready=0, o_valid=1, o_acc stable.
  - o_ready=1 -> at that edge the accumulator and sticky flags clear -> ACC.
  - o_ready=0 -> hold indefinitely.
- Latency: last term accepted at edge k -> o_valid=1 from edge k+1.
- o_acc drives the accumulator register directly.

i_clear:
- Honoured only in ACC state; ignored in DRAIN and OUT.
- Zeroes the accumulator, drops the stage-1 term, and clears the sticky flags.
- If i_valid is also high in the same cycle, that term is accepted as the first term of the new sum.
- i_clear with i_valid & i_last: the sum contains only that term.

Other rules:
- Zero products (P=0) are legal and add 0 regardless of i_exp.
- Back-to-back sums: the first term of the next sum is accepted in the cycle after the OUT handshake.
- RST asserted mid-sum discards all state immediately; no partial o_valid is produced.

Test Plan:
- 1.0*1.0 split as i_sum=0x0F0000, i_carry=0x010000, i_exp=30, sign=0, last=1 -> o_acc=0x1_0000_0000_0000 (2^48) one edge after accept, o_exception=0, o_overflow=0.
- Terms +1.0 (P=0x100000, exp=30) then -1.0 (sign=1), last on the second term -> o_acc=0. Also check i_ready=0 during DRAIN/OUT.
- Extremes: P=0x3FF001 at exp=60 (65504^2) -> o_acc=0x3FF001<<58. Separately, P=1 at exp=2 (min subnormal^2) -> o_acc=1.
- 2^15 back-to-back max terms (i_valid always high) -> o_overflow stays 0 and o_acc=2^15*(0x3FF001<<58). With o_ready=0 for 5 cycles, o_acc holds; after the handshake a new term is accepted the next cycle.
- Third of four terms has i_exception=1 -> o_exception=1, and o_acc equals the sum of the other three.
- i_clear together with i_valid mid-sum, then last -> o_acc equals only the post-clear terms.
- RST pulse during ACC with stage 1 full -> all outputs 0 and no o_valid appears.
